fifo_burst_reader: RTL



---
 rtl/fifo_burst_reader_pkg.sv | 12 +
 rtl/fifo_burst_reader_skid_buffer.sv | 56 +++++
 rtl/fifo_burst_reader.sv | 109 ++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the burst reader and its output skid buffer.
package fifo_burst_reader_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_OCC_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_burst_reader_skid_buffer.sv
// Two-entry in-order output stage; a word written here is offered on the stream next cycle.
module fifo_burst_reader_skid_buffer
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [WIDTH-1:0]      data,
  output logic [SKID_OCC_W-1:0] occ
);

  logic [WIDTH-1:0]      mem [SKID_DEPTH];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [SKID_OCC_W-1:0] occ_q;
  logic                  take;

  assign valid = (occ_q != '0);
  assign take  = valid & ready;
  assign occ   = occ_q;
  // Head entry is never the write target while occupied, so it stays stable under stall.
  assign data  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (take) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, take})
        2'b10:   occ_q <= occ_q + SKID_OCC_W'(1);
        2'b01:   occ_q <= occ_q - SKID_OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pop-side FIFO controller: starts a burst on occupancy threshold or idle timeout,
// drains a snapshot of the occupancy through a skid buffer, and tags the last word.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 8,
  parameter int LOG_BUFFER_DEPTH = (BUFFER_DEPTH <= 1) ? 1 : $clog2(BUFFER_DEPTH),
  parameter int TMO_WIDTH        = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      flush_i,
  input  logic [LOG_BUFFER_DEPTH:0] thresh_i,
  input  logic [TMO_WIDTH-1:0]      tmo_i,
  input  logic                      fifo_empty_i,
  input  logic [LOG_BUFFER_DEPTH:0] fifo_cnt_i,
  input  logic [DATA_WIDTH-1:0]     fifo_dat_i,
  output logic                      fifo_pop_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_WIDTH-1:0]     dat_o,
  output logic                      last_o,
  output logic                      tmo_o,
  output logic                      busy_o,
  output logic                      state_o
);

  localparam int CW = LOG_BUFFER_DEPTH + 1;

  state_e                state_q;
  logic [CW-1:0]         remaining_q;
  logic [TMO_WIDTH-1:0]  tmo_cnt_q;

  logic [CW-1:0]         thresh_eff;
  logic                  thresh_met;
  logic                  tmo_hit;
  logic                  start;
  logic                  live;
  logic                  pop;
  logic [SKID_OCC_W-1:0] skid_occ;
  logic [DATA_WIDTH:0]   skid_data;

  assign thresh_eff = (thresh_i == '0) ? CW'(1) : thresh_i;
  assign thresh_met = (fifo_cnt_i >= thresh_eff);
  assign tmo_hit    = !fifo_empty_i && (tmo_i != '0) && (tmo_cnt_q == tmo_i - TMO_WIDTH'(1));
  assign start      = (state_q == IDLE) && en_i && (thresh_met || tmo_hit);
  assign live       = !rst_i && !flush_i;

  assign pop = live && (state_q == BURST) && (remaining_q != '0) && !fifo_empty_i &&
               (skid_occ < SKID_OCC_W'(SKID_DEPTH));

  assign fifo_pop_o = pop;
  // A start where the threshold also holds counts as a threshold start.
  assign tmo_o      = live && start && tmo_hit && !thresh_met;
  assign busy_o     = (state_q == BURST) || (skid_occ != '0);
  assign state_o    = (state_q == BURST);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= BURST;
            remaining_q <= fifo_cnt_i;
            tmo_cnt_q   <= '0;
          end else if (fifo_empty_i) begin
            tmo_cnt_q <= '0;
          end else if (en_i && !thresh_met && (tmo_cnt_q != '1)) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_WIDTH'(1);
          end
        end
        BURST: begin
          if (remaining_q == '0) begin
            state_q <= IDLE;
          end else if (pop) begin
            remaining_q <= remaining_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stream handshake: a word transfers on any cycle with valid_o and ready_i both high;
  // once valid_o is raised it stays high, and dat_o/last_o stay fixed, until that transfer.
  fifo_burst_reader_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk_i),
    .rst      (rst_i),
    .flush    (flush_i),
    .push     (pop),
    .push_data({fifo_dat_i, (remaining_q == CW'(1))}),
    .ready    (ready_i),
    .valid    (valid_o),
    .data     (skid_data),
    .occ      (skid_occ)
  );

  assign dat_o  = skid_data[DATA_WIDTH:1];
  assign last_o = skid_data[0];

endmodule
